// File: rtl/word_window_ctrl.sv
// Game-flow controller: fills and shifts the six-slot word-id window, buffers typed keys and tracks progress.
// Optional error counter output err_cnt is enabled by defining WWC_ERR_COUNT_EN.
module word_window_ctrl #(
  parameter int unsigned NUM_WORDS = 100,
  parameter logic [15:0] SEED      = 16'h0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  input  logic [74:0]  cur_word,
  input  logic [4:0]   cur_len,
  output logic         key_ready,
  output logic [59:0]  rd,
  output logic [124:0] type_buf,
  output logic [4:0]   correct,
  output logic [4:0]   tot,
  output logic         word_done,
  output logic [9:0]   word_cnt
`ifdef WWC_ERR_COUNT_EN
  ,
  output logic [9:0]   err_cnt
`endif
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [8:0]  NUM_W    = 9'(NUM_WORDS);

  typedef enum logic [1:0] {ST_INIT, ST_TYPE, ST_SHIFT} state_t;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [2:0]     fill_q, fill_d;
  logic [59:0]    rd_q, rd_d;
  logic [124:0]   type_q, type_d;
  logic [4:0]     tot_q, tot_d;
  logic [4:0]     correct_q, correct_d;
  logic [9:0]     word_cnt_q, word_cnt_d;
  logic           word_done_q, word_done_d;
  logic           key_ready_q, key_ready_d;

  logic [15:0]    lfsr_step;
  logic [7:0]     new_id;
  logic [4:0]     cur_char;
  logic           is_letter, is_space, is_bksp;
  logic           space_done, space_wrong, hit, append;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign new_id    = 8'(({1'b0, lfsr_q[7:0]}) % NUM_W);

  assign is_letter   = (key_code >= 5'd1) && (key_code <= 5'd26);
  assign is_space    = (key_code == 5'd27);
  assign is_bksp     = (key_code == 5'd28);
  assign space_done  = is_space && (correct_q == cur_len) && (tot_q == cur_len);
  assign space_wrong = is_space && !space_done;
  assign append      = (is_letter || space_wrong) && (tot_q < 5'd25);
  assign hit         = is_letter && append && (correct_q == tot_q) &&
                       (tot_q < cur_len) && (key_code == cur_char);

  // Target character at the current typing position; beyond the longest word there is none.
  always_comb begin
    cur_char = 5'd0;
    for (int i = 0; i < 15; i++) begin
      if (tot_q == 5'(i)) cur_char = cur_word[5*i +: 5];
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    type_d      = type_q;
    tot_d       = tot_q;
    correct_d   = correct_q;
    word_cnt_d  = word_cnt_q;
    word_done_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        for (int k = 0; k < 6; k++) begin
          if (fill_q == 3'(k)) rd_d[10*k +: 10] = {2'b00, new_id};
        end
        lfsr_d = lfsr_step;
        if (fill_q == 3'd5) begin
          fill_d  = 3'd0;
          state_d = ST_TYPE;
        end else begin
          fill_d = fill_q + 3'd1;
        end
      end
      ST_TYPE: begin
        if (key_valid) begin
          if (space_done) begin
            state_d = ST_SHIFT;
          end else if (append) begin
            for (int i = 0; i < 25; i++) begin
              if (tot_q == 5'(i)) type_d[5*i +: 5] = key_code;
            end
            tot_d = tot_q + 5'd1;
            if (hit) correct_d = correct_q + 5'd1;
          end else if (is_bksp && (tot_q != 5'd0)) begin
            for (int i = 0; i < 25; i++) begin
              if (tot_q == 5'(i + 1)) type_d[5*i +: 5] = 5'd0;
            end
            tot_d = tot_q - 5'd1;
            if (correct_q == tot_q) correct_d = correct_q - 5'd1;
          end
        end
      end
      ST_SHIFT: begin
        rd_d        = {2'b00, new_id, rd_q[59:10]};
        lfsr_d      = lfsr_step;
        type_d      = '0;
        tot_d       = 5'd0;
        correct_d   = 5'd0;
        if (word_cnt_q != 10'd1023) word_cnt_d = word_cnt_q + 10'd1;
        word_done_d = 1'b1;
        state_d     = ST_TYPE;
      end
      default: state_d = ST_INIT;
    endcase
    key_ready_d = (state_d == ST_TYPE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      lfsr_q      <= SEED_EFF;
      fill_q      <= 3'd0;
      rd_q        <= '0;
      type_q      <= '0;
      tot_q       <= 5'd0;
      correct_q   <= 5'd0;
      word_cnt_q  <= 10'd0;
      word_done_q <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      type_q      <= type_d;
      tot_q       <= tot_d;
      correct_q   <= correct_d;
      word_cnt_q  <= word_cnt_d;
      word_done_q <= word_done_d;
      key_ready_q <= key_ready_d;
    end
  end

`ifdef WWC_ERR_COUNT_EN
  // Every wrong letter or non-completing space counts, even when the buffer is full.
  logic       err_inc;
  logic [9:0] err_cnt_q, err_cnt_d;

  assign err_inc = (state_q == ST_TYPE) && key_valid && (is_letter || space_wrong) && !hit;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 10'd1023)) err_cnt_d = err_cnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) err_cnt_q <= 10'd0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign key_ready = key_ready_q;
  assign rd        = rd_q;
  assign type_buf  = type_q;
  assign correct   = correct_q;
  assign tot       = tot_q;
  assign word_done = word_done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_word_window_ctrl.sv
// Directed scoreboard bench for word_window_ctrl: expectations are queued as each key is driven
// and popped one cycle later, when the registered outputs reflect that key.
module tb_word_window_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [4:0]   key_code;
  logic [74:0]  cur_word;
  logic [4:0]   cur_len;
  logic         key_ready;
  logic [59:0]  rd;
  logic [124:0] type_buf;
  logic [4:0]   correct;
  logic [4:0]   tot;
  logic         word_done;
  logic [9:0]   word_cnt;

  always #5 clk = ~clk;

  word_window_ctrl #(.NUM_WORDS(100), .SEED(16'h0001)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cur_word  (cur_word),
    .cur_len   (cur_len),
    .key_ready (key_ready),
    .rd        (rd),
    .type_buf  (type_buf),
    .correct   (correct),
    .tot       (tot),
    .word_done (word_done),
    .word_cnt  (word_cnt)
  );

  typedef struct {
    string        tag;
    logic [59:0]  rd;
    logic [124:0] type_buf;
    logic [4:0]   tot;
    logic [4:0]   correct;
    logic [9:0]   word_cnt;
    logic         word_done;
    logic         key_ready;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [59:0]  e_rd;
  logic [124:0] e_type;
  logic [4:0]   e_tot, e_correct;
  logic [9:0]   e_word_cnt;
  logic         e_word_done, e_key_ready;

  function automatic logic [59:0] rd_pack(input int s0, input int s1, input int s2,
                                          input int s3, input int s4, input int s5);
    return {2'b00, 8'(s5), 2'b00, 8'(s4), 2'b00, 8'(s3),
            2'b00, 8'(s2), 2'b00, 8'(s1), 2'b00, 8'(s0)};
  endfunction

  task automatic clearExp();
    e_rd = '0; e_type = '0; e_tot = '0; e_correct = '0;
    e_word_cnt = '0; e_word_done = 1'b0; e_key_ready = 1'b0;
  endtask

  task automatic pushExp(input string tag);
    exp_t e;
    e.tag = tag; e.rd = e_rd; e.type_buf = e_type; e.tot = e_tot; e.correct = e_correct;
    e.word_cnt = e_word_cnt; e.word_done = e_word_done; e.key_ready = e_key_ready;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [124:0] obs,
                     input logic [124:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "rd",        125'(rd),        125'(e.rd));
    chk(e.tag, "type",      type_buf,        e.type_buf);
    chk(e.tag, "tot",       125'(tot),       125'(e.tot));
    chk(e.tag, "correct",   125'(correct),   125'(e.correct));
    chk(e.tag, "word_cnt",  125'(word_cnt),  125'(e.word_cnt));
    chk(e.tag, "word_done", 125'(word_done), 125'(e.word_done));
    chk(e.tag, "key_ready", 125'(key_ready), 125'(e.key_ready));
  endtask

  // Drive one cycle of key input, then leave the bench sampling 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [4:0] code);
    key_valid = valid;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic keyStep(input string tag, input logic [4:0] code, input int t, input int c);
    e_tot     = 5'(t);
    e_correct = 5'(c);
    pushExp(tag);
    applyStimulus(1'b1, code);
    checkOutput();
  endtask

  // Expects the LFSR sequence 1,2,4,8,16,32 to fill the slots one per cycle from reset.
  task automatic doInit(input int n_slots);
    int ids[6] = '{1, 2, 4, 8, 16, 32};
    clearExp();
    for (int k = 0; k < n_slots; k++) begin
      e_rd[10*k +: 10] = 10'(ids[k]);
      e_key_ready = (k == 5);
      pushExp($sformatf("init_slot%0d", k));
      applyStimulus(1'b0, 5'd0);
      checkOutput();
    end
  endtask

  task automatic resetStep(input string tag);
    rst = 1'b0;
    clearExp();
    pushExp(tag);
    applyStimulus(1'b1, 5'd3);
    checkOutput();
    rst = 1'b1;
  endtask

  task automatic typeCat();
    e_type[4:0] = 5'd3;    keyStep("cat_c", 5'd3, 1, 1);
    e_type[9:5] = 5'd1;    keyStep("cat_a", 5'd1, 2, 2);
    e_type[14:10] = 5'd20; keyStep("cat_t", 5'd20, 3, 3);
  endtask

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 5'd0;
    cur_word  = {60'd0, 5'd20, 5'd1, 5'd3};
    cur_len   = 5'd3;
    @(posedge clk);
    #1;

    resetStep("reset");
    doInit(6);

    typeCat();
    e_key_ready = 1'b0;
    keyStep("space_done", 5'd27, 3, 3);

    e_rd = rd_pack(2, 4, 8, 16, 32, 64);
    e_type = '0; e_word_cnt = 10'd1; e_word_done = 1'b1; e_key_ready = 1'b1;
    keyStep("shift_drop_key", 5'd3, 0, 0);
    e_word_done = 1'b0;
    pushExp("after_shift");
    applyStimulus(1'b0, 5'd0);
    checkOutput();

    e_type[4:0] = 5'd3;    keyStep("wrong_c", 5'd3, 1, 1);
    e_type[9:5] = 5'd9;    keyStep("wrong_i", 5'd9, 2, 1);
    e_type[14:10] = 5'd20; keyStep("wrong_t", 5'd20, 3, 1);
    e_type[14:10] = 5'd0;  keyStep("bksp1", 5'd28, 2, 1);
    e_type[9:5] = 5'd0;    keyStep("bksp2", 5'd28, 1, 1);
    e_type[9:5] = 5'd1;    keyStep("fix_a", 5'd1, 2, 2);
    e_type[14:10] = 5'd20; keyStep("fix_t", 5'd20, 3, 3);
    e_type[14:10] = 5'd0;  keyStep("bksp_correct", 5'd28, 2, 2);
    e_type[14:10] = 5'd27; keyStep("space_wrong", 5'd27, 3, 2);
    e_type[14:10] = 5'd0;  keyStep("clr1", 5'd28, 2, 2);
    e_type[9:5] = 5'd0;    keyStep("clr2", 5'd28, 1, 1);
    e_type[4:0] = 5'd0;    keyStep("clr3", 5'd28, 0, 0);
    keyStep("bksp_empty", 5'd28, 0, 0);
    keyStep("ignored_0", 5'd0, 0, 0);
    keyStep("ignored_29", 5'd29, 0, 0);

    // key_valid held high: every cycle is a fresh 'x' until the buffer saturates.
    key_valid = 1'b1;
    key_code  = 5'd24;
    for (int i = 0; i < 26; i++) begin
      if (i < 25) begin
        e_type[5*i +: 5] = 5'd24;
        e_tot = 5'(i + 1);
      end
      pushExp($sformatf("held_x%0d", i));
      @(posedge clk);
      #1;
      checkOutput();
    end
    key_valid = 1'b0;
    keyStep("full_letter_drop", 5'd26, 25, 0);
    keyStep("full_space_drop", 5'd27, 25, 0);

    resetStep("reset_in_type");
    doInit(2);
    resetStep("reset_init_cycle3");
    doInit(6);
    typeCat();
    e_key_ready = 1'b0;
    keyStep("space_done2", 5'd27, 3, 3);
    resetStep("reset_in_shift");
    doInit(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
